pwm_ramp_ctrl: RTL
==================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the duty/target/step width in bits.
REQ-002 The block SHALL have parameter RESET_DUTY, default 0, giving the duty value loaded on reset.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port run  input  1  level; high allows ramping and PWM output, low forces IDLE.
REQ-006 Port cmd_valid  input  1  new target command present.
REQ-007 Port cmd_ready  output  1  block can accept a command this cycle.
REQ-008 Port cmd_target  input  WIDTH  requested final duty value.
REQ-009 Port cmd_step  input  WIDTH  duty change per PWM period; 0 SHALL be treated as 1.
REQ-010 Port period_complete  input  1  one-cycle strobe from the PWM counter at count wrap.
REQ-011 Port pwm_enable  output  1  enable for the PWM counter.
REQ-012 Port duty_cycle  output  WIDTH  registered duty value driven to the PWM counter.
REQ-013 Port busy  output  1  high while in RAMP.
REQ-014 Port done  output  1  one-cycle pulse when duty_cycle reaches target.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RAMP, HOLD.
REQ-016 Command handshake: a transfer SHALL occur when cmd_valid && cmd_ready; cmd_ready = (state != RAMP), combinational from state only.
REQ-017 On transfer: target and step (0 mapped to 1) SHALL be latched, and duty_cycle SHALL NOT change in that cycle.
REQ-018 IDLE: pwm_enable=0; when run=1, next state SHALL be RAMP if duty_cycle != target, else HOLD.
REQ-019 HOLD: pwm_enable=1; a transfer whose target != duty_cycle SHALL move to RAMP next cycle; an equal target SHALL stay in HOLD with no done pulse.
REQ-020 RAMP step rule: on a cycle with period_complete=1, if |target - duty_cycle| <= step, duty_cycle SHALL be set to target.
REQ-021 RAMP step rule (continued): in that case the state SHALL become HOLD and done SHALL pulse high one cycle later, aligned with the HOLD entry.
REQ-022 RAMP step rule (continued): otherwise duty_cycle SHALL move toward target by step.
REQ-023 Arithmetic SHALL use WIDTH+1 bits; duty_cycle SHALL never wrap, overshoot target, or leave 0..2^WIDTH-1.
REQ-024 duty_cycle SHALL change only on period_complete cycles in RAMP, so each PWM period uses a single duty value.
REQ-025 run=0 in RAMP or HOLD SHALL force IDLE next cycle with duty_cycle frozen and target retained; the ramp resumes from the frozen duty_cycle when run returns.
REQ-026 period_complete in IDLE or HOLD SHALL be ignored.
REQ-027 A transfer and period_complete in the same HOLD cycle: the transfer SHALL win and no step SHALL occur that cycle.

Reset
REQ-028 While reset=1 (synchronous): state=IDLE, duty_cycle=RESET_DUTY, target=RESET_DUTY, step=1, pwm_enable=0, busy=0, done=0.
REQ-029 In the cycle after reset deasserts, cmd_ready SHALL be 1 (IDLE).
REQ-030 Reset asserted mid-RAMP SHALL abandon the ramp with no done pulse.

Structure
REQ-031 Shared package pwm_pkg SHALL hold the state enum (IDLE/RAMP/HOLD) and the default WIDTH constant, for reuse by the PWM counter and future channels.
REQ-032 The next-duty computation (compare, add/subtract, clamp to target) SHALL be a combinational sub-module pwm_ramp_step; the FSM and registers remain in pwm_ramp_ctrl.
REQ-033 pwm_enable and duty_cycle SHALL be registered outputs.

Verification
REQ-034 Reset, then run=1 with no command -> HOLD next cycle, duty_cycle=0, pwm_enable=1, done=0.
REQ-035 From HOLD with duty 0: target=10, step=3 -> duty steps 3, 6, 9, 10 on successive period_complete strobes; done pulses once, then HOLD.
REQ-036 From duty 250: target=255, step=10 -> duty becomes 255 in one strobe (no wrap); next, target=0, step=0 -> duty decrements by 1 per strobe.
REQ-037 Mid-ramp at duty 40 (target 100): run=0 -> IDLE with pwm_enable=0 and duty held at 40; run=1 -> ramp continues from 40; cmd_valid is ignored while busy=1.
REQ-038 In HOLD, cmd_valid and period_complete asserted in the same cycle -> command accepted, duty unchanged that cycle, stepping starts at the next strobe.
REQ-039 reset asserted during RAMP at duty 70 -> next cycle duty=0, state IDLE, done=0, cmd_ready=1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: ramp controller state encoding and default channel width.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// Next-duty computation: one step toward target, clamped so the duty never overshoots or wraps.
module pwm_ramp_step
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next_duty,
    output logic             reached
);

    logic [WIDTH:0] duty_ext;
    logic [WIDTH:0] target_ext;
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] diff;
    logic           up;

    assign duty_ext   = {1'b0, duty};
    assign target_ext = {1'b0, target};
    assign step_ext   = {1'b0, step};

    assign up      = target_ext > duty_ext;
    assign diff    = up ? (target_ext - duty_ext) : (duty_ext - target_ext);
    assign reached = diff <= step_ext;

    // Outside the reach window the full step is strictly inside the range, so truncation is exact.
    always_comb begin
        next_duty = target;
        if (!reached) begin
            if (up) begin
                next_duty = WIDTH'(duty_ext + step_ext);
            end else begin
                next_duty = WIDTH'(duty_ext - step_ext);
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller: accepts target/step commands and walks duty_cycle toward target
// one step per PWM period.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned     WIDTH      = PWM_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [WIDTH-1:0] cmd_step,
    input  logic             period_complete,
    output logic             pwm_enable,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             busy,
    output logic             done
);

    pwm_state_e       state_q;
    pwm_state_e       state_d;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] target_d;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] duty_d;
    logic             pwm_enable_d;
    logic             busy_d;
    logic             done_d;
    logic             xfer;
    logic [WIDTH-1:0] step_next;
    logic             step_reached;

    assign cmd_ready = (state_q != RAMP);
    assign xfer      = cmd_valid && cmd_ready;

    pwm_ramp_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .duty      (duty_cycle),
        .target    (target_q),
        .step      (step_q),
        .next_duty (step_next),
        .reached   (step_reached)
    );

    // Next state, latched command and next duty; a transfer always takes priority over stepping.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        step_d   = step_q;
        duty_d   = duty_cycle;
        done_d   = 1'b0;

        if (xfer) begin
            target_d = cmd_target;
            step_d   = (cmd_step == '0) ? WIDTH'(1) : cmd_step;
        end

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = (duty_cycle != target_d) ? RAMP : HOLD;
                end
            end
            HOLD: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (xfer && (cmd_target != duty_cycle)) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (period_complete) begin
                    duty_d = step_next;
                    if (step_reached) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        pwm_enable_d = (state_d != IDLE);
        busy_d       = (state_d == RAMP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= RESET_DUTY;
            step_q     <= WIDTH'(1);
            duty_cycle <= RESET_DUTY;
            pwm_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            step_q     <= step_d;
            duty_cycle <= duty_d;
            pwm_enable <= pwm_enable_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule
